// File: rtl/tiny_riscv_uart_rx.sv
// tiny_riscv_uart_rx: 8N1 serial receiver with a small byte FIFO.
// Line -> 2-flop synchroniser -> bit-timing FSM -> FIFO -> processor read port.
// Sticky overrun/frame-error flags are cleared by firmware.
module tiny_riscv_uart_rx #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst,
    input  logic                          i_UART_RX,
    input  logic                          i_read_strobe,
    input  logic                          i_clear_errors,
    output logic [7:0]                    o_rx_data,
    output logic                          o_rx_valid,
    output logic [$clog2(FIFO_DEPTH):0]   o_rx_count,
    output logic                          o_overrun,
    output logic                          o_frame_error
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int TW   = $clog2(CLKS_PER_BIT);
    localparam int HALF = (CLKS_PER_BIT - 1) / 2;
    // Timer reaches its last value exactly HALF cycles after leaving IDLE.
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_LOAD = TW'(CLKS_PER_BIT - HALF);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            sync1_q, sync1_d;
    logic            sync2_q, sync2_d;
    logic [1:0]      fill_q, fill_d;
    logic            rx_prev_q, rx_prev_d;
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic            overrun_q, overrun_d;
    logic            frame_err_q, frame_err_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];

    logic rx_s, rx_fall, tick, empty, full, pop;
    logic push, set_ovr, set_fe;

    // rx_s only counts as a real line sample once both synchroniser stages
    // have captured the pin after reset; this keeps a line held low across
    // reset release from looking like a start edge.
    assign rx_s    = sync2_q;
    assign rx_fall = fill_q[1] & rx_prev_q & ~rx_s;
    assign tick    = (timer_q == T_LAST);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop     = i_read_strobe & ~empty;

    assign o_rx_valid    = ~empty;
    assign o_rx_count    = wr_ptr_q - rd_ptr_q;
    assign o_rx_data     = empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
    assign o_overrun     = overrun_q;
    assign o_frame_error = frame_err_q;

    // Receive FSM: start detect, mid-bit sampling, stop-bit disposition.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        push    = 1'b0;
        set_ovr = 1'b0;
        set_fe  = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_fall) begin
                    state_d = START;
                    timer_d = T_LOAD;
                end
            end
            START: begin
                if (tick) begin
                    timer_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        idx_d   = 3'd0;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            DATA: begin
                if (tick) begin
                    timer_d = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            STOP: begin
                if (tick) begin
                    timer_d = '0;
                    state_d = IDLE;
                    if (!rx_s) begin
                        set_fe = 1'b1;
                    end else if (!full || pop) begin
                        // A pop on the same edge frees the slot in a full FIFO.
                        push = 1'b1;
                    end else begin
                        set_ovr = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Synchroniser, FIFO pointers/storage and sticky error flags.
    always_comb begin
        sync1_d     = i_UART_RX;
        sync2_d     = sync1_q;
        fill_d      = {fill_q[0], 1'b1};
        rx_prev_d   = fill_q[1] ? rx_s : rx_prev_q;
        wr_ptr_d    = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d    = rd_ptr_q + (AW+1)'(pop);
        mem_d       = mem_q;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = shift_q;
        end
        // A set event in the same cycle as a clear leaves the flag set.
        overrun_d   = (overrun_q & ~i_clear_errors) | set_ovr;
        frame_err_d = (frame_err_q & ~i_clear_errors) | set_fe;
    end

    // Control and status registers with asynchronous reset.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            idx_q       <= 3'd0;
            shift_q     <= 8'h00;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            fill_q      <= 2'b00;
            rx_prev_q   <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            fill_q      <= fill_d;
            rx_prev_q   <= rx_prev_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    // FIFO storage; contents are only visible through valid pointers.
    always_ff @(posedge i_Clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_tiny_riscv_uart_rx.sv
// Directed bench for tiny_riscv_uart_rx at CLKS_PER_BIT=8, FIFO_DEPTH=4.
module tb_tiny_riscv_uart_rx;
    localparam int CPB = 8;

    logic       i_Clk = 1'b0;
    logic       i_Rst;
    logic       i_UART_RX;
    logic       i_read_strobe;
    logic       i_clear_errors;
    logic [7:0] o_rx_data;
    logic       o_rx_valid;
    logic [2:0] o_rx_count;
    logic       o_overrun;
    logic       o_frame_error;

    int errors = 0;
    int checks = 0;

    tiny_riscv_uart_rx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_UART_RX(i_UART_RX),
        .i_read_strobe(i_read_strobe), .i_clear_errors(i_clear_errors),
        .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid), .o_rx_count(o_rx_count),
        .o_overrun(o_overrun), .o_frame_error(o_frame_error)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic step(input int n);
        repeat (n) @(posedge i_Clk);
        #1;
    endtask

    task automatic drive_bit(input logic b);
        i_UART_RX = b;
        step(CPB);
    endtask

    // Full frame; optional pop pulse lands exactly on the stop-sample edge
    // (edge 78 counted from the start-bit fall: 3 sync/detect + H=3 + 9*8).
    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic pop_at_stop);
        drive_bit(1'b0);
        for (int k = 0; k < 8; k++) drive_bit(d[k]);
        i_UART_RX = stop_b;
        if (pop_at_stop) begin
            step(5);
            i_read_strobe = 1'b1;
            step(1);
            i_read_strobe = 1'b0;
            step(2);
        end else begin
            step(CPB);
        end
    endtask

    task automatic pop_one();
        i_read_strobe = 1'b1;
        step(1);
        i_read_strobe = 1'b0;
    endtask

    task automatic clear_errs();
        i_clear_errors = 1'b1;
        step(1);
        i_clear_errors = 1'b0;
    endtask

    task automatic test_reset();
        i_Rst = 1'b1; i_UART_RX = 1'b1; i_read_strobe = 1'b0; i_clear_errors = 1'b0;
        step(3);
        checks++; if (o_rx_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", o_rx_count); end
        checks++; if (o_rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", o_rx_valid); end
        checks++; if (o_rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", o_rx_data); end
        checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%b exp=0", o_overrun); end
        checks++; if (o_frame_error !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b exp=0", o_frame_error); end
        i_Rst = 1'b0;
        step(5);
    endtask

    task automatic test_single();
        send_frame(8'h55, 1'b1, 1'b0);
        checks++; if (o_rx_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", o_rx_valid); end
        checks++; if (o_rx_data !== 8'h55) begin errors++; $display("FAIL single_data got=%h exp=55", o_rx_data); end
        checks++; if (o_rx_count !== 3'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", o_rx_count); end
        pop_one();
        checks++; if (o_rx_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid got=%b exp=0", o_rx_valid); end
        checks++; if (o_rx_count !== 3'd0) begin errors++; $display("FAIL single_pop_count got=%0d exp=0", o_rx_count); end
        checks++; if (o_rx_data !== 8'h00) begin errors++; $display("FAIL single_pop_data got=%h exp=00", o_rx_data); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [4];
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'hA5; exp_b[3] = 8'h3C;
        for (int i = 0; i < 4; i++) send_frame(exp_b[i], 1'b1, 1'b0);
        checks++; if (o_rx_count !== 3'd4) begin errors++; $display("FAIL b2b_count got=%0d exp=4", o_rx_count); end
        checks++; if (o_overrun !== 1'b0 || o_frame_error !== 1'b0) begin errors++; $display("FAIL b2b_flags got=%b%b exp=00", o_overrun, o_frame_error); end
        i_read_strobe = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (o_rx_data !== exp_b[i]) begin errors++; $display("FAIL b2b_data%0d got=%h exp=%h", i, o_rx_data, exp_b[i]); end
            step(1);
        end
        i_read_strobe = 1'b0;
        checks++; if (o_rx_count !== 3'd0 || o_rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got=%0d/%b exp=0/0", o_rx_count, o_rx_valid); end
    endtask

    task automatic test_overrun();
        logic [7:0] exp_o [4];
        exp_o[0] = 8'h02; exp_o[1] = 8'h03; exp_o[2] = 8'h04; exp_o[3] = 8'h06;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 1'b0);
        checks++; if (o_rx_count !== 3'd4) begin errors++; $display("FAIL ovr_count got=%0d exp=4", o_rx_count); end
        checks++; if (o_overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got=%b exp=1", o_overrun); end
        checks++; if (o_rx_data !== 8'h01) begin errors++; $display("FAIL ovr_head got=%h exp=01", o_rx_data); end
        checks++; if (o_frame_error !== 1'b0) begin errors++; $display("FAIL ovr_frame_err got=%b exp=0", o_frame_error); end
        clear_errs();
        checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got=%b exp=0", o_overrun); end
        send_frame(8'h06, 1'b1, 1'b1);
        checks++; if (o_rx_count !== 3'd4) begin errors++; $display("FAIL ovr_pushpop_count got=%0d exp=4", o_rx_count); end
        checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL ovr_pushpop_flag got=%b exp=0", o_overrun); end
        i_read_strobe = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (o_rx_data !== exp_o[i]) begin errors++; $display("FAIL ovr_data%0d got=%h exp=%h", i, o_rx_data, exp_o[i]); end
            step(1);
        end
        i_read_strobe = 1'b0;
        checks++; if (o_rx_count !== 3'd0) begin errors++; $display("FAIL ovr_drained got=%0d exp=0", o_rx_count); end
    endtask

    task automatic test_frame_error();
        send_frame(8'h81, 1'b0, 1'b0);
        i_UART_RX = 1'b1;
        step(1);
        checks++; if (o_rx_count !== 3'd0) begin errors++; $display("FAIL fe_count got=%0d exp=0", o_rx_count); end
        checks++; if (o_frame_error !== 1'b1) begin errors++; $display("FAIL fe_flag got=%b exp=1", o_frame_error); end
        checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL fe_overrun got=%b exp=0", o_overrun); end
        clear_errs();
        checks++; if (o_frame_error !== 1'b0) begin errors++; $display("FAIL fe_clear got=%b exp=0", o_frame_error); end
        step(10);
    endtask

    task automatic test_glitch();
        i_UART_RX = 1'b0;
        step(2);
        i_UART_RX = 1'b1;
        step(20);
        checks++; if (o_rx_count !== 3'd0 || o_rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_count got=%0d/%b exp=0/0", o_rx_count, o_rx_valid); end
        checks++; if (o_overrun !== 1'b0 || o_frame_error !== 1'b0) begin errors++; $display("FAIL glitch_flags got=%b%b exp=00", o_overrun, o_frame_error); end
        send_frame(8'hC3, 1'b1, 1'b0);
        checks++; if (o_rx_data !== 8'hC3 || o_rx_count !== 3'd1) begin errors++; $display("FAIL glitch_after got=%h/%0d exp=c3/1", o_rx_data, o_rx_count); end
        pop_one();
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'h11, 1'b1, 1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        i_Rst = 1'b1;
        #2;
        checks++; if (o_rx_count !== 3'd0 || o_rx_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_count got=%0d/%b exp=0/0", o_rx_count, o_rx_valid); end
        checks++; if (o_rx_data !== 8'h00) begin errors++; $display("FAIL rst_mid_data got=%h exp=00", o_rx_data); end
        checks++; if (o_overrun !== 1'b0 || o_frame_error !== 1'b0) begin errors++; $display("FAIL rst_mid_flags got=%b%b exp=00", o_overrun, o_frame_error); end
        i_UART_RX = 1'b1;
        step(2);
        i_Rst = 1'b0;
        step(20);
        send_frame(8'h42, 1'b1, 1'b0);
        checks++; if (o_rx_valid !== 1'b1 || o_rx_count !== 3'd1) begin errors++; $display("FAIL rst_after_count got=%0d/%b exp=1/1", o_rx_count, o_rx_valid); end
        checks++; if (o_rx_data !== 8'h42) begin errors++; $display("FAIL rst_after_data got=%h exp=42", o_rx_data); end
        checks++; if (o_overrun !== 1'b0 || o_frame_error !== 1'b0) begin errors++; $display("FAIL rst_after_flags got=%b%b exp=00", o_overrun, o_frame_error); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overrun();
        test_frame_error();
        test_glitch();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tiny_riscv_uart_rx.md
# tiny_riscv_uart_rx

Memory-mapped UART receiver for the tiny RISC-V SoC: deserialises 8N1 frames from the board's RX pin and buffers received bytes in a small FIFO. It is the counterpart of the existing transmit path and sits between `i_UART_RX` and the processor's peripheral read-data mux. Firmware polls `o_rx_valid` through the UART control word, and a read of the UART data word pops one byte.

## Interface
- `CLKS_PER_BIT`, 217, clock cycles per bit (25 MHz / 115200); must be ≥ 4.
- `FIFO_DEPTH`, 4, byte entries; power of two, ≥ 2.
- `i_Clk` input 1: system clock.
- `i_Rst` input 1: reset, asynchronous, active-high.
- `i_UART_RX` input 1: serial line, idle high, asynchronous to `i_Clk`.
- `i_read_strobe` input 1: one-cycle pop request, asserted when the processor reads the UART data word.
- `i_clear_errors` input 1: one-cycle clear of the sticky error flags.
- `o_rx_data` output 8: FIFO head byte; meaningful only while `o_rx_valid`=1, otherwise 0x00.
- `o_rx_valid` output 1: FIFO non-empty.
- `o_rx_count` output $clog2(FIFO_DEPTH)+1: number of bytes held.
- `o_overrun` output 1: sticky; a byte was dropped because the FIFO was full.
- `o_frame_error` output 1: sticky; a stop bit was sampled low.

## Operation
- Line input passes through a 2-flop synchroniser; both flops reset to 1. `rx_s` is the synchronised value.
- The FSM has four states: IDLE, START, DATA, STOP. One bit-timer counts 0..CLKS_PER_BIT-1, and a 3-bit index selects the data bit.
- **IDLE:** when `rx_s`=0 (its previous value was 1), go to START and load the timer so that the start-bit sample occurs H = (CLKS_PER_BIT-1)/2 cycles later (integer divide).
- **START:** at the sample point, if `rx_s`=1, treat it as a glitch and return to IDLE with no flags set. If `rx_s`=0, go to DATA with index 0.
- **DATA:** sample every CLKS_PER_BIT cycles and shift in LSB first. After bit 7, go to STOP.
- **STOP:** sample one bit period after bit 7.
  - Stop bit = 1, FIFO not full: push the byte.
  - Stop bit = 1, FIFO full: drop the byte and set `o_overrun`.
  - Stop bit = 0: discard the byte and set `o_frame_error`.
  - In every case, return to IDLE on the same cycle. A new start edge can then be detected immediately, which tolerates a short stop bit.
- FIFO uses read/write pointers with an extra wrap bit. Full when the pointers differ only in the MSB; empty when they are equal. Pointers wrap modulo 2·FIFO_DEPTH.
- A pop when empty is ignored.
- Push and pop in the same cycle:
  - Non-empty FIFO: both occur and the count is unchanged.
  - Empty FIFO: only the push occurs.
  - Full FIFO: the pop frees a slot, the push is accepted, and no overrun is flagged.
- Sticky flags clear only on `i_clear_errors` or reset. A set event in the same cycle as a clear wins (flag stays 1).
- Reset values: FSM in IDLE, pointers 0, `o_rx_valid`=0, `o_rx_count`=0, `o_rx_data`=0x00, both flags 0. Reset mid-frame abandons the frame. A line still low after reset release is ignored until `rx_s` has been seen high.

## Timing
- Synchroniser latency: 2 cycles from pin to `rx_s`.
- Let t0 be the cycle the FSM leaves IDLE. Sample points:
  - start bit: t0+H
  - data bit k: t0+H+(k+1)·CLKS_PER_BIT
  - stop bit: t0+H+9·CLKS_PER_BIT
- The FIFO write occurs at the stop-sample clock edge. `o_rx_valid`, `o_rx_count` and `o_rx_data` update on the following cycle (registered status).
- A pop at edge n updates `o_rx_data`, `o_rx_count` and `o_rx_valid` by edge n+1, so back-to-back pops on consecutive cycles are legal.
- `o_overrun` and `o_frame_error` assert on the cycle after the stop sample.
- Sustained back-to-back frames at nominal baud lose no bytes, provided the FIFO is drained.

## Test plan
- CLKS_PER_BIT=8, single frame 0x55 → one cycle after the stop sample, `o_rx_valid`=1, `o_rx_data`=0x55, `o_rx_count`=1. Pop → `o_rx_valid`=0, `o_rx_count`=0.
- Back-to-back frames 0x00, 0xFF, 0xA5, 0x3C with no idle gap, then 4 pops → data read in that order, no flags set.
- Five frames with no pops (FIFO_DEPTH=4) → count 4, `o_overrun`=1, head still the first byte. Then pop at the exact stop-sample cycle of a sixth frame → sixth byte accepted, no further overrun.
- Frame 0x81 with stop bit held low → nothing pushed, `o_frame_error`=1. Then `i_clear_errors` → flag 0.
- A 2-cycle low glitch on an idle line → FSM returns to IDLE, count 0, no flags. Assert `i_Rst` mid-DATA → all outputs at reset values; the next clean frame 0x42 is received correctly.
